// File: rtl/queue_arb_pkg.sv
// Shared types for the queue arbiter: FSM state encoding and burst counter width.
package queue_arb_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        BURSTING = 1'b1
    } arb_state_t;

    localparam int BCNT_W = 8;

endpackage

// File: rtl/queue_arb_rr_pick.sv
// Combinational rotate-and-pick: first asserted request at or after ptr, wrapping.
module queue_arb_rr_pick #(
    parameter int NUM_Q = 4,
    localparam int QW = $clog2(NUM_Q)
) (
    input  logic [NUM_Q-1:0] req,
    input  logic [QW-1:0]    ptr,
    output logic [QW-1:0]    gnt_idx,
    output logic             gnt_any
);

    always_comb begin
        int idx;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NUM_Q; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_Q) idx = idx - NUM_Q;
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = QW'(idx);
            end
        end
    end

endmodule

// File: rtl/queue_arb.sv
// Burst round-robin arbiter draining NUM_Q FIFOs into one registered output stage.
// Optional QUEUE_ARB_PRIO0_EN gives queue 0 strict priority over all bursts.
module queue_arb
    import queue_arb_pkg::*;
#(
    parameter int NUM_Q  = 4,
    parameter int DWIDTH = 24,
    parameter int BURST  = 4,
    localparam int QW = $clog2(NUM_Q)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_Q-1:0]        q_vld,
    input  logic [NUM_Q*DWIDTH-1:0] q_data,
    output logic [NUM_Q-1:0]        q_pop,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [DWIDTH-1:0]       out_data,
    output logic [QW-1:0]           out_qid,
    output logic                    busy
);

    // Handshake: an entry moves downstream on any rising edge with out_vld && out_rdy;
    // the output register may be refilled on that same edge, so a pop is allowed
    // whenever the register is empty or is being drained this cycle.

    localparam logic [BCNT_W-1:0] BURST_MAX = BCNT_W'(BURST);
    localparam logic [QW-1:0]     LAST_Q    = QW'(NUM_Q - 1);

    arb_state_t        state;
    logic [QW-1:0]     rr_ptr;
    logic [QW-1:0]     cur_q;
    logic [BCNT_W-1:0] burst_cnt;

    logic              can_pop;
    logic              bursting;
    logic              cont;
    logic              prio0;
    logic [QW-1:0]     next_q;
    logic [QW-1:0]     pick_ptr;
    logic [QW-1:0]     pick_idx;
    logic              pick_any;
    logic [QW-1:0]     gnt_idx;
    logic              gnt_any;
    logic              pop;

    assign can_pop  = !rst && (!out_vld || out_rdy);
    assign bursting = (state == BURSTING);
    assign next_q   = (cur_q == LAST_Q) ? '0 : cur_q + 1'b1;
    assign cont     = bursting && q_vld[cur_q] && (burst_cnt < BURST_MAX);
    // Ending a burst arbitrates from the queue after cur_q in the same cycle.
    assign pick_ptr = bursting ? next_q : rr_ptr;

`ifdef QUEUE_ARB_PRIO0_EN
    assign prio0 = q_vld[0];
`else
    assign prio0 = 1'b0;
`endif

    queue_arb_rr_pick #(
        .NUM_Q(NUM_Q)
    ) u_pick (
        .req    (q_vld),
        .ptr    (pick_ptr),
        .gnt_idx(pick_idx),
        .gnt_any(pick_any)
    );

    assign gnt_idx = prio0 ? '0 : (cont ? cur_q : pick_idx);
    assign gnt_any = prio0 || cont || pick_any;
    assign pop     = can_pop && gnt_any;
    assign busy    = bursting;

    always_comb begin
        q_pop = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            q_pop[i] = pop && (gnt_idx == QW'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cur_q     <= '0;
            burst_cnt <= '0;
            out_vld   <= 1'b0;
            out_data  <= '0;
            out_qid   <= '0;
        end else begin
            if (pop) begin
                out_vld  <= 1'b1;
                out_data <= q_data[int'(gnt_idx)*DWIDTH +: DWIDTH];
                out_qid  <= gnt_idx;
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end

            // Everything below is frozen while the output is stalled.
            if (can_pop) begin
                if (prio0) begin
                    state <= IDLE;
                end else if (cont) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end else begin
                    if (bursting) rr_ptr <= next_q;
                    if (pick_any) begin
                        cur_q     <= pick_idx;
                        burst_cnt <= BCNT_W'(1);
                        state     <= BURSTING;
                    end else begin
                        state <= IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_queue_arb.sv
// Scoreboarded bench for queue_arb (NUM_Q=4, BURST=2) with FIFO models per queue.
module tb_queue_arb;

    localparam int NQ    = 4;
    localparam int DW    = 24;
    localparam int BURST = 2;
    localparam int QW    = 2;
    localparam int EW    = QW + DW;

    logic               clk = 1'b0;
    logic               rst;
    logic [NQ-1:0]      q_vld;
    logic [NQ-1:0]      q_pop;
    logic [NQ-1:0]      en;
    logic [NQ*DW-1:0]   q_data;
    logic               out_vld;
    logic               out_rdy;
    logic               busy;
    logic [DW-1:0]      out_data;
    logic [QW-1:0]      out_qid;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit rnd_mode = 1'b0;

    logic [DW-1:0] mem [NQ][16];
    logic [7:0]    wr [NQ];
    logic [7:0]    rd [NQ] = '{default: 8'd0};
    logic [7:0]    exp_seq [NQ];
    logic [7:0]    rcv [NQ] = '{default: 8'd0};
    logic [EW-1:0] exp_q [$];
    int            xfer_cyc [$];

    queue_arb #(
        .NUM_Q (NQ),
        .DWIDTH(DW),
        .BURST (BURST)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .q_vld   (q_vld),
        .q_data  (q_data),
        .q_pop   (q_pop),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_data(out_data),
        .out_qid (out_qid),
        .busy    (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- FIFO models ----------------
    for (genvar i = 0; i < NQ; i++) begin : g_fifo
        assign q_vld[i]            = en[i] && (wr[i] != rd[i]);
        assign q_data[i*DW +: DW]  = mem[i][rd[i][3:0]];
    end

    always @(posedge clk) begin
        for (int i = 0; i < NQ; i++) begin
            if (q_pop[i]) rd[i] <= rd[i] + 8'd1;
        end
    end

    function automatic logic [DW-1:0] dat(input int q, input logic [7:0] s);
        return {8'(q), 8'h00, s};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int q, input int n);
        for (int k = 0; k < n; k++) begin
            mem[q][wr[q][3:0]] = dat(q, wr[q]);
            wr[q] = wr[q] + 8'd1;
        end
    endtask

    // Expected grant order as hex nibbles, first grant in bits [3:0].
    task automatic ex_seq(input int n, input logic [63:0] qs);
        int q;
        for (int k = 0; k < n; k++) begin
            q = int'(qs[k*4 +: 4]);
            exp_q.push_back({QW'(q), dat(q, exp_seq[q])});
            exp_seq[q] = exp_seq[q] + 8'd1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || out_vld) && k < budget) begin
            step();
            k++;
        end
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_contig(input string name, input int n);
        check({name, "_count"}, 32'(xfer_cyc.size()), 32'(n));
        if (xfer_cyc.size() > 0)
            check({name, "_contig"}, 32'(xfer_cyc[$] - xfer_cyc[0]), 32'(n - 1));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst) begin
            n_checks++;
            if (!$onehot0(q_pop) || (q_pop & ~q_vld) != '0) begin
                n_errors++;
                $display("FAIL pop_legal q_pop=%b q_vld=%b", q_pop, q_vld);
            end
            if (out_vld && out_rdy) begin
                xfer_cyc.push_back(cyc);
                n_checks++;
                if (rnd_mode) begin
                    if (out_data !== dat(int'(out_qid), rcv[out_qid])) begin
                        n_errors++;
                        $display("FAIL order qid=%0d data=%h required=%h", out_qid, out_data,
                                 dat(int'(out_qid), rcv[out_qid]));
                    end
                end else if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected qid=%0d data=%h required=none", out_qid, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_qid, out_data} !== e) begin
                        n_errors++;
                        $display("FAIL xfer actual=%0d/%h required=%0d/%h",
                                 out_qid, out_data, e[EW-1 -: QW], e[DW-1:0]);
                    end
                end
                rcv[out_qid] = out_data[7:0] + 8'd1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] base0;
        int k;
        rst = 1'b1;
        en = '0;
        out_rdy = 1'b1;
        for (int i = 0; i < NQ; i++) begin
            wr[i] = 8'd0;
            exp_seq[i] = 8'd0;
        end
        #1;
        check("rst_q_pop", 32'(q_pop), 32'd0);
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_qid", 32'(out_qid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // All queues valid: bursts of two in rotation, no bubbles.
        for (int i = 0; i < NQ; i++) push(i, 3);
        xfer_cyc.delete();
`ifdef QUEUE_ARB_PRIO0_EN
        ex_seq(12, 64'h3213_3221_1000);
`else
        ex_seq(12, 64'h3210_3322_1100);
`endif
        en = 4'hF;
        wait_drain("rr_all", 100);
        check_contig("rr_all", 12);
        check("rr_all_busy", 32'(busy), 32'd0);

        // Single queue: burst end re-arbitrates back to itself seamlessly.
        en = '0;
        push(2, 5);
        xfer_cyc.delete();
        ex_seq(5, 64'h22222);
        en = 4'b0100;
        wait_drain("solo", 100);
        check_contig("solo", 5);
        check("solo_out_vld", 32'(out_vld), 32'd0);
        check("solo_busy", 32'(busy), 32'd0);

        // Output stall: everything holds for three cycles, then resumes.
        en = '0;
        base0 = wr[0];
        push(0, 3);
        push(1, 2);
`ifdef QUEUE_ARB_PRIO0_EN
        ex_seq(5, 64'h11000);
`else
        ex_seq(5, 64'h01100);
`endif
        out_rdy = 1'b0;
        en = 4'b0011;
        step();
        for (int s = 0; s < 3; s++) begin
            check("stall_out_vld", 32'(out_vld), 32'd1);
            check("stall_out_qid", 32'(out_qid), 32'd0);
            check("stall_out_data", 32'(out_data), 32'(dat(0, base0)));
            check("stall_q_pop", 32'(q_pop), 32'd0);
            if (s < 2) step();
        end
        out_rdy = 1'b1;
        wait_drain("stall", 100);

        // Reset in the middle of a queue 3 burst discards the held entry.
        en = '0;
        push(3, 4);
        push(1, 2);
        en = 4'b1000;
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_out_vld", 32'(out_vld), 32'd0);
        check("mid_rst_q_pop", 32'(q_pop), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        exp_seq[3] = exp_seq[3] + 8'd1;
        ex_seq(5, 64'h33311);
        en = 4'b1010;
        step();
        step();
        rst = 1'b0;
        wait_drain("post_rst", 100);

        // Queue 0 arrives while queue 1 is mid-burst.
        en = '0;
        push(1, 3);
        push(0, 1);
`ifdef QUEUE_ARB_PRIO0_EN
        ex_seq(4, 64'h1101);
`else
        ex_seq(4, 64'h1011);
`endif
        en = 4'b0010;
        step();
        en = 4'b0011;
        wait_drain("q0_arrive", 100);

        // Random valids and back-pressure; per-queue order and no loss.
        rnd_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            en = 4'($urandom_range(0, 15));
            out_rdy = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, NQ - 1);
            if ($urandom_range(0, 1) == 1 && 8'(wr[k] - rd[k]) < 8'd14) push(k, 1);
            step();
        end
        en = 4'hF;
        out_rdy = 1'b1;
        k = 0;
        while ((q_vld != '0 || out_vld) && k < 300) begin
            step();
            k++;
        end
        for (int i = 0; i < NQ; i++) check("rnd_no_loss", 32'(rcv[i]), 32'(wr[i]));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/queue_arb.md
QUEUE_ARB -- requirements
Module: queue_arb

Interface
REQ-001 SHALL have parameter NUM_Q, default 4: number of requesting FIFOs (2..16).
REQ-002 SHALL have parameter DWIDTH, default 24: entry width.
REQ-003 SHALL have parameter BURST, default 4: maximum consecutive grants to one queue (1..255).
REQ-004 SHALL have localparam QW = $clog2(NUM_Q): queue-id width.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port q_vld, input, NUM_Q: per-queue FIFO vld (non-empty).
REQ-008 SHALL have port q_data, input, NUM_Q*DWIDTH: per-queue FIFO data_out, queue i at bits [i*DWIDTH +: DWIDTH].
REQ-009 SHALL have port q_pop, output, NUM_Q: per-queue pop, at most one bit high.
REQ-010 SHALL have port out_vld, output, 1: output entry valid.
REQ-011 SHALL have port out_rdy, input, 1: downstream accepts; transfer = out_vld && out_rdy.
REQ-012 SHALL have port out_data, output, DWIDTH: granted entry.
REQ-013 SHALL have port out_qid, output, QW: source queue of out_data.
REQ-014 SHALL have port busy, output, 1: high while in state BURSTING.

Function
REQ-015 SHALL pop queue g (q_pop[g]=1) only when q_vld[g]=1 and the output register is free (out_vld=0 or out_rdy=1); q_pop SHALL be combinational from current state and inputs.
REQ-016 SHALL capture q_data[g] and g into out_data/out_qid on the edge where q_pop[g]=1, setting out_vld=1 (one-cycle pop-to-out_vld latency).
REQ-017 SHALL clear out_vld on a transfer cycle with no pop; a transfer with a pop SHALL reload out_data with no bubble (one entry per cycle sustained).
REQ-018 SHALL hold out_data/out_qid/out_vld stable while out_vld=1 and out_rdy=0.
REQ-019 SHALL implement FSM states IDLE and BURSTING.
REQ-020 IDLE: SHALL select the lowest-index valid queue at or after rr_ptr (wrapping modulo NUM_Q); on pop, cur_q <= g, burst_cnt <= 1, go to BURSTING.
REQ-021 BURSTING: SHALL keep granting cur_q while q_vld[cur_q]=1 and burst_cnt < BURST, incrementing burst_cnt per pop.
REQ-022 BURSTING: when burst_cnt == BURST or q_vld[cur_q]=0 at a pop opportunity, SHALL set rr_ptr <= cur_q+1 (wrap NUM_Q-1 -> 0) and re-arbitrate in the same cycle as IDLE would; if no queue valid, go to IDLE.
REQ-023 SHALL freeze FSM, burst_cnt and rr_ptr while output is stalled (out_vld=1, out_rdy=0).
REQ-024 burst_cnt SHALL be 8 bits and never exceed BURST.
REQ-025 BURST=1 SHALL yield pure per-entry round robin.
REQ-026 A queue dropping q_vld mid-burst SHALL not be popped; the burst ends per REQ-022.

Reset
REQ-027 On rst=1, SHALL immediately force: state IDLE, rr_ptr 0, cur_q 0, burst_cnt 0, out_vld 0, out_data 0, out_qid 0, busy 0; q_pop all 0 while rst=1.
REQ-028 Reset asserted mid-burst SHALL discard the registered entry; first grant after release follows REQ-020 from rr_ptr 0.

Configuration
REQ-029 Macro QUEUE_ARB_PRIO0_EN: when defined, queue 0 SHALL have strict priority — whenever q_vld[0]=1 at a pop opportunity it SHALL be granted, preempting any burst (preempted burst restarts via REQ-020, rr_ptr unchanged); queue 0 grants SHALL not touch burst_cnt/rr_ptr.
REQ-030 When undefined, queue 0 SHALL be an ordinary round-robin participant.

Structure
REQ-031 SHALL place the FSM state enum (IDLE, BURSTING) and the burst_cnt width constant in package queue_arb_pkg.
REQ-032 SHALL implement rotate-and-pick in sub-module queue_arb_rr_pick (inputs req, ptr; outputs gnt_idx, gnt_any), purely combinational.

Verification
REQ-033 NUM_Q=4, BURST=2, all q_vld=1, out_rdy=1 -> out_qid 0,0,1,1,2,2,3,3,0 on consecutive cycles.
REQ-034 Only q_vld[2]=1 holding 5 entries, BURST=4 -> qid 2 x4, then re-arbitrate to 2 with no bubble, qid 2 once more, then out_vld=0, IDLE.
REQ-035 out_rdy=0 for 3 cycles with out_vld=1 -> out_data/out_qid stable, q_pop=0, burst_cnt unchanged; resumes exactly where stalled.
REQ-036 rst pulsed mid-burst on queue 3 -> out_vld=0 and q_pop=0 immediately; first grant after release is lowest valid queue >= 0.
REQ-037 With QUEUE_ARB_PRIO0_EN, queue 1 bursting, q_vld[0] rises -> next pop is queue 0; without the macro, queue 1 finishes its burst first.
REQ-038 Random q_vld/out_rdy, 10k cycles -> q_pop one-hot-or-zero, never pop on q_vld=0, per-queue output order matches push order, no loss or duplication.
